silife_sim_ctrl: RTL and testbench

SILIFE_SIM_CTRL -- requirements
Module: silife_sim_ctrl

---
 rtl/silife_pkg.sv | 33 +++
 rtl/silife_step_timer.sv | 28 ++
 rtl/silife_sim_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_silife_sim_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/silife_pkg.sv
// Shared definitions for the silife simulation controller: register map,
// controller FSM states, display-channel register stride and CTRL field layout.
package silife_pkg;

    localparam logic [23:0] ADDR_CTRL      = 24'h000;
    localparam logic [23:0] ADDR_CONFIG    = 24'h004;
    localparam logic [23:0] ADDR_PERIOD    = 24'h008;
    localparam logic [23:0] ADDR_GEN       = 24'h00C;
    localparam logic [23:0] ADDR_TARGET    = 24'h010;
    localparam logic [23:0] ADDR_IRQ_STAT  = 24'h014;
    localparam logic [23:0] ADDR_IRQ_EN    = 24'h018;
    localparam logic [23:0] ADDR_DISP_BASE = 24'h100;

    // Each display channel owns a CTRL word and a BRIGHT word.
    localparam int unsigned DISP_STRIDE = 8;
    localparam int unsigned DISP_SHIFT  = $clog2(DISP_STRIDE);
    localparam int unsigned MAX_DISPLAYS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } sim_state_e;

    // CTRL register write payload, bit 2 down to bit 0.
    typedef struct packed {
        logic count_mode;
        logic step;
        logic run;
    } ctrl_bits_t;

endpackage

// File: rtl/silife_step_timer.sv
// Auto-step period timer: loads a period, counts down to zero and holds there.
module silife_step_timer #(
    parameter int unsigned PERIOD_BITS = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [PERIOD_BITS-1:0] load_value,
    input  logic                   dec,
    output logic                   zero_c
);

    logic [PERIOD_BITS-1:0] count;

    // Load has priority over decrement; the count never underflows.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - PERIOD_BITS'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/silife_sim_ctrl.sv
// Game-of-life simulation controller: Wishbone register file, auto/single
// step sequencing with generation counting, and MAX7219 display channel control.
// Optional interrupt block is built only when SILIFE_IRQ_EN is defined.
module silife_sim_ctrl
    import silife_pkg::*;
#(
    parameter int unsigned NUM_DISPLAYS = 1,
    parameter int unsigned PERIOD_BITS  = 24,
    parameter int unsigned GEN_BITS     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_wb_cyc,
    input  logic                      i_wb_stb,
    input  logic                      i_wb_we,
    input  logic [31:0]               i_wb_addr,
    input  logic [31:0]               i_wb_data,
    output logic                      o_wb_ack,
    output logic [31:0]               o_wb_data,
    output logic                      o_step,
    output logic                      o_wrap,
    output logic [NUM_DISPLAYS-1:0]   o_disp_enable,
    output logic [NUM_DISPLAYS-1:0]   o_disp_frame,
    input  logic [NUM_DISPLAYS-1:0]   i_disp_busy,
    output logic [4*NUM_DISPLAYS-1:0] o_disp_brightness,
    output logic                      o_irq
);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        wb_hit, wb_wr, wb_rd;
    logic [23:0] addr;
    logic [23:0] disp_off;
    logic        disp_hit;
    logic [2:0]  disp_idx;
    logic        disp_bright_sel;
    logic        wr_ctrl, wr_config, wr_period, wr_gen, wr_target, wr_disp;
    ctrl_bits_t  ctrl_wdata;
    logic        unused_bits;

    assign wb_hit     = i_wb_cyc & i_wb_stb;
    assign wb_wr      = wb_hit & i_wb_we;
    assign wb_rd      = wb_hit & ~i_wb_we;
    assign addr       = i_wb_addr[23:0];
    assign ctrl_wdata = ctrl_bits_t'(i_wb_data[2:0]);
    assign unused_bits = ^{i_wb_addr[31:24], i_wb_data};

    // Addresses below the display base wrap to a large offset and miss.
    assign disp_off        = addr - ADDR_DISP_BASE;
    assign disp_hit        = (disp_off < 24'(DISP_STRIDE * NUM_DISPLAYS)) && (disp_off[1:0] == 2'b00);
    assign disp_idx        = disp_off[DISP_SHIFT +: 3];
    assign disp_bright_sel = disp_off[2];

    assign wr_ctrl   = wb_wr && (addr == ADDR_CTRL);
    assign wr_config = wb_wr && (addr == ADDR_CONFIG);
    assign wr_period = wb_wr && (addr == ADDR_PERIOD);
    assign wr_gen    = wb_wr && (addr == ADDR_GEN);
    assign wr_target = wb_wr && (addr == ADDR_TARGET);
    assign wr_disp   = wb_wr && disp_hit;

    // ------------------------------------------------------------------
    // Control registers and FSM
    // ------------------------------------------------------------------
    sim_state_e            state_q, state_d;
    logic                  ctrl_run, ctrl_count, step_req;
    logic [PERIOD_BITS-1:0] period_q;
    logic [GEN_BITS-1:0]   gen_q, target_q, gen_inc;
    logic                  timer_load, timer_dec, timer_zero;
    logic                  hit_target, step_ok, step_take;

    assign step_ok   = !ctrl_run && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign step_take = (state_d == ST_STEP) && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    silife_step_timer #(
        .PERIOD_BITS (PERIOD_BITS)
    ) u_step_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (period_q),
        .dec        (timer_dec),
        .zero_c     (timer_zero)
    );

    // Next-state and timer control; run has priority over a pending single step.
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        hit_target = 1'b0;
        gen_inc    = gen_q + GEN_BITS'(1);
        case (state_q)
            ST_IDLE: begin
                if (ctrl_run) begin
                    state_d    = ST_WAIT;
                    timer_load = 1'b1;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
            ST_WAIT: begin
                if (!ctrl_run) begin
                    state_d = ST_IDLE;
                end else if (timer_zero) begin
                    state_d = ST_STEP;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_STEP: begin
                if (ctrl_count && (gen_inc == target_q)) begin
                    state_d    = ST_DONE;
                    hit_target = 1'b1;
                end else if (ctrl_run) begin
                    state_d    = ST_WAIT;
                    timer_load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = step_req ? ST_STEP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; the step strobe is registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            o_step  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_step  <= (state_d == ST_STEP);
        end
    end

    // Software-visible control registers and the generation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_run   <= 1'b0;
            ctrl_count <= 1'b0;
            step_req   <= 1'b0;
            o_wrap     <= 1'b0;
            period_q   <= '0;
            gen_q      <= '0;
            target_q   <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_run   <= ctrl_wdata.run;
                ctrl_count <= ctrl_wdata.count_mode;
            end
            if (hit_target) begin
                ctrl_run <= 1'b0;
            end
            if (step_take) begin
                step_req <= 1'b0;
            end
            if (wr_ctrl && ctrl_wdata.step && step_ok) begin
                step_req <= 1'b1;
            end
            if (wr_ctrl && ctrl_wdata.run) begin
                step_req <= 1'b0;
            end
            if (wr_config) begin
                o_wrap <= i_wb_data[0];
            end
            if (wr_period) begin
                period_q <= i_wb_data[PERIOD_BITS-1:0];
            end
            if (wr_target) begin
                target_q <= i_wb_data[GEN_BITS-1:0];
            end
            // A software clear beats a step landing in the same cycle.
            if (wr_gen) begin
                gen_q <= '0;
            end else if (state_q == ST_STEP) begin
                gen_q <= gen_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display channels
    // ------------------------------------------------------------------
    logic [NUM_DISPLAYS-1:0]   disp_enable, disp_pause, disp_frame;
    logic [4*NUM_DISPLAYS-1:0] disp_bright;

    // Per-channel registers; frame drops once the channel reports busy,
    // unless software is rewriting that channel's control word this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_enable <= '0;
            disp_pause  <= '0;
            disp_frame  <= '1;
            disp_bright <= '1;
        end else begin
            for (int k = 0; k < int'(NUM_DISPLAYS); k++) begin
                if (wr_disp && (disp_idx == 3'(k)) && !disp_bright_sel) begin
                    disp_enable[k] <= i_wb_data[0];
                    disp_pause[k]  <= i_wb_data[1];
                    disp_frame[k]  <= i_wb_data[2];
                end else if (i_disp_busy[k]) begin
                    disp_frame[k] <= 1'b0;
                end
                if (wr_disp && (disp_idx == 3'(k)) && disp_bright_sel) begin
                    disp_bright[4*k +: 4] <= i_wb_data[3:0];
                end
            end
        end
    end

    // Registered frame request: free-running unless paused.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_disp_frame <= '1;
        end else begin
            o_disp_frame <= ~disp_pause | disp_frame;
        end
    end

    assign o_disp_enable     = disp_enable;
    assign o_disp_brightness = disp_bright;

    // ------------------------------------------------------------------
    // Interrupts
    // ------------------------------------------------------------------
    logic [1:0] irq_stat_rd, irq_en_rd;

`ifdef SILIFE_IRQ_EN
    logic [1:0]              irq_stat, irq_en, irq_set;
    logic [NUM_DISPLAYS-1:0] busy_q;
    logic                    wr_irq_stat, wr_irq_en;

    assign wr_irq_stat = wb_wr && (addr == ADDR_IRQ_STAT);
    assign wr_irq_en   = wb_wr && (addr == ADDR_IRQ_EN);
    assign irq_set     = {|(busy_q & ~i_disp_busy), (state_q == ST_DONE)};
    assign irq_stat_rd = irq_stat;
    assign irq_en_rd   = irq_en;

    // Sticky status with write-one-to-clear; a new event beats the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_stat <= '0;
            irq_en   <= '0;
            busy_q   <= '0;
            o_irq    <= 1'b0;
        end else begin
            busy_q   <= i_disp_busy;
            irq_stat <= (irq_stat & ~(wr_irq_stat ? i_wb_data[1:0] : 2'b00)) | irq_set;
            if (wr_irq_en) begin
                irq_en <= i_wb_data[1:0];
            end
            o_irq <= |(irq_stat & irq_en);
        end
    end
`else
    assign irq_stat_rd = 2'b00;
    assign irq_en_rd   = 2'b00;
    assign o_irq       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] rd_data_c;

    // Read mux; anything not mapped reads as zero.
    always_comb begin
        rd_data_c = '0;
        if (disp_hit) begin
            for (int k = 0; k < int'(NUM_DISPLAYS); k++) begin
                if (disp_idx == 3'(k)) begin
                    rd_data_c = disp_bright_sel
                              ? {28'd0, disp_bright[4*k +: 4]}
                              : {28'd0, i_disp_busy[k], disp_frame[k], disp_pause[k], disp_enable[k]};
                end
            end
        end else begin
            case (addr)
                ADDR_CTRL:     rd_data_c = {29'd0, ctrl_count, 1'b0, ctrl_run};
                ADDR_CONFIG:   rd_data_c = {31'd0, o_wrap};
                ADDR_PERIOD:   rd_data_c = 32'(period_q);
                ADDR_GEN:      rd_data_c = 32'(gen_q);
                ADDR_TARGET:   rd_data_c = 32'(target_q);
                ADDR_IRQ_STAT: rd_data_c = {30'd0, irq_stat_rd};
                ADDR_IRQ_EN:   rd_data_c = {30'd0, irq_en_rd};
                default:       rd_data_c = '0;
            endcase
        end
    end

    // Every strobed cycle is acknowledged on the next cycle with its read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack  <= wb_hit;
            o_wb_data <= wb_rd ? rd_data_c : '0;
        end
    end

endmodule

// File: tb/tb_silife_sim_ctrl.sv
// Bench for silife_sim_ctrl (2 display channels, 8-bit generation counter).
// Works in both builds; SILIFE_IRQ_EN selects the interrupt expectations.
module tb_silife_sim_ctrl;

    localparam int ND = 2;
    localparam int PB = 24;
    localparam int GB = 8;
`ifdef SILIFE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    localparam logic [31:0] A_CTRL = 32'h000, A_CONFIG = 32'h004, A_PERIOD = 32'h008;
    localparam logic [31:0] A_GEN = 32'h00C, A_TARGET = 32'h010, A_IRQS = 32'h014, A_IRQE = 32'h018;

    logic              clk, reset;
    logic              cyc, stb, we;
    logic [31:0]       addr, wdata;
    logic              ack;
    logic [31:0]       rdata;
    logic              step, wrap, irq;
    logic [ND-1:0]     disp_en, disp_frame, disp_busy;
    logic [4*ND-1:0]   disp_bright;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int step_q[$];

    silife_sim_ctrl #(
        .NUM_DISPLAYS (ND),
        .PERIOD_BITS  (PB),
        .GEN_BITS     (GB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i_wb_cyc          (cyc),
        .i_wb_stb          (stb),
        .i_wb_we           (we),
        .i_wb_addr         (addr),
        .i_wb_data         (wdata),
        .o_wb_ack          (ack),
        .o_wb_data         (rdata),
        .o_step            (step),
        .o_wrap            (wrap),
        .o_disp_enable     (disp_en),
        .o_disp_frame      (disp_frame),
        .i_disp_busy       (disp_busy),
        .o_disp_brightness (disp_bright),
        .o_irq             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Record the cycle of every observed step strobe.
    always @(negedge clk) begin
        if (step) step_q.push_back(cycle);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int c);
        c     = cycle;
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        tick();
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        check("ack", {31'd0, ack}, 32'd1);
        rd = rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int c;
        wb_xfer(1'b1, a, d, rd, c);
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int c;
        wb_xfer(1'b0, a, 32'd0, rd, c);
        check(name, rd, exp);
    endtask

    // Reference: after run is written in cycle c with period p, steps land at
    // c+3+p and every p+2 cycles after, up to one cycle past the stop write d.
    task automatic run_burst(input int p, input int len);
        logic [31:0] rd;
        int c, d;
        int exp_q[$];
        wr(A_GEN, 32'd0);
        wr(A_PERIOD, 32'(p));
        step_q.delete();
        wb_xfer(1'b1, A_CTRL, 32'd1, rd, c);
        repeat (len) tick();
        wb_xfer(1'b1, A_CTRL, 32'd0, rd, d);
        repeat (p + 6) tick();
        for (int t = c + 3 + p; t <= d + 1; t += p + 2) exp_q.push_back(t);
        check("burst_count", 32'(step_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check("burst_step_cycle", (i < step_q.size()) ? 32'(step_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
        rd_check("burst_gen", A_GEN, 32'(exp_q.size() % (1 << GB)));
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } tv_t;

    tv_t tv [24];

    initial begin
        logic [31:0] rd;
        int c, w;

        tv[0]  = '{1'b0, A_CTRL,          32'h0,        32'h0};
        tv[1]  = '{1'b0, A_GEN,           32'h0,        32'h0};
        tv[2]  = '{1'b0, 32'h104,         32'h0,        32'hF};
        tv[3]  = '{1'b0, 32'h100,         32'h0,        32'h4};
        tv[4]  = '{1'b0, 32'h10C,         32'h0,        32'hF};
        tv[5]  = '{1'b0, A_PERIOD,        32'h0,        32'h0};
        tv[6]  = '{1'b0, A_TARGET,        32'h0,        32'h0};
        tv[7]  = '{1'b0, A_IRQS,          32'h0,        32'h0};
        tv[8]  = '{1'b1, A_PERIOD,        32'hFF123456, 32'h0};
        tv[9]  = '{1'b0, A_PERIOD,        32'h0,        32'h00123456};
        tv[10] = '{1'b1, A_TARGET,        32'hDEADBEEF, 32'h0};
        tv[11] = '{1'b0, A_TARGET,        32'h0,        32'hEF};
        tv[12] = '{1'b1, 32'h10C,         32'hA5,       32'h0};
        tv[13] = '{1'b0, 32'h10C,         32'h0,        32'h5};
        tv[14] = '{1'b0, 32'h110,         32'h0,        32'h0};
        tv[15] = '{1'b1, 32'h0FC,         32'h5,        32'h0};
        tv[16] = '{1'b0, 32'h0FC,         32'h0,        32'h0};
        tv[17] = '{1'b1, A_IRQE,          32'h3,        32'h0};
        tv[18] = '{1'b0, A_IRQE,          32'h0,        IRQ_ON ? 32'h3 : 32'h0};
        tv[19] = '{1'b1, A_IRQE,          32'h0,        32'h0};
        tv[20] = '{1'b0, A_CONFIG,        32'h0,        32'h0};
        tv[21] = '{1'b0, 32'h102,         32'h0,        32'h0};
        tv[22] = '{1'b0, 32'h01C,         32'h0,        32'h0};
        tv[23] = '{1'b0, 32'h01000008,    32'h0,        32'h00123456};

        reset = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; disp_busy = '0;
        repeat (3) tick();

        // Reset state
        check("rst_ack",    {31'd0, ack},   32'd0);
        check("rst_rdata",  rdata,          32'd0);
        check("rst_step",   {31'd0, step},  32'd0);
        check("rst_wrap",   {31'd0, wrap},  32'd0);
        check("rst_irq",    {31'd0, irq},   32'd0);
        check("rst_frame",  32'(disp_frame), 32'h3);
        check("rst_enable", 32'(disp_en),    32'h0);
        check("rst_bright", 32'(disp_bright), 32'hFF);
        reset = 1'b0;
        tick();

        // Register map vectors; ack must fall again the cycle after it rises
        for (int i = 0; i < 24; i++) begin
            wb_xfer(tv[i].we, tv[i].addr, tv[i].wdata, rd, c);
            if (!tv[i].we) check($sformatf("reg_vec%0d", i), rd, tv[i].exp);
            tick();
            check("ack_one_cycle", {31'd0, ack}, 32'd0);
        end

        wr(A_CONFIG, 32'd1);
        tick();
        check("wrap_on", {31'd0, wrap}, 32'd1);
        rd_check("config_rd", A_CONFIG, 32'd1);
        wr(A_CONFIG, 32'd0);
        tick();
        check("wrap_off", {31'd0, wrap}, 32'd0);

        // Auto-step cadence: fixed case, period 0 across the counter wrap, random
        run_burst(3, 50);
        run_burst(0, 520);
        repeat (6) run_burst(int'($urandom_range(0, 7)), int'($urandom_range(4, 60)));

        // Count mode stops at target and raises the done interrupt
        wr(A_GEN, 32'd0);
        wr(A_PERIOD, 32'd1);
        wr(A_TARGET, 32'd4);
        wr(A_IRQE, 32'd1);
        step_q.delete();
        wr(A_CTRL, 32'd5);
        repeat (60) tick();
        check("count_steps", 32'(step_q.size()), 32'd4);
        rd_check("count_ctrl", A_CTRL, 32'd4);
        rd_check("count_gen", A_GEN, 32'd4);
        rd_check("count_irqstat", A_IRQS, IRQ_ON ? 32'd1 : 32'd0);
        check("count_irq", {31'd0, irq}, IRQ_ON ? 32'd1 : 32'd0);
        wr(A_IRQS, 32'd1);
        repeat (2) tick();
        check("w1c_irq", {31'd0, irq}, 32'd0);
        rd_check("w1c_irqstat", A_IRQS, 32'd0);
        wr(A_CTRL, 32'd0);
        wr(A_IRQE, 32'd0);

        // Single step from idle
        wr(A_GEN, 32'd0);
        step_q.delete();
        wb_xfer(1'b1, A_CTRL, 32'd2, rd, c);
        repeat (4) tick();
        check("single_count", 32'(step_q.size()), 32'd1);
        check("single_cycle", (step_q.size() > 0) ? 32'(step_q[0]) : 32'hFFFF_FFFF, 32'(c + 2));
        rd_check("single_gen", A_GEN, 32'd1);
        rd_check("single_ctrl", A_CTRL, 32'd0);

        // GEN clear landing on a step cycle wins over the increment
        wr(A_GEN, 32'd0);
        wr(A_PERIOD, 32'd0);
        step_q.delete();
        wb_xfer(1'b1, A_CTRL, 32'd1, rd, c);
        while (cycle < c + 9) tick();
        wb_xfer(1'b1, A_GEN, 32'd0, rd, w);
        wr(A_CTRL, 32'd0);
        repeat (6) tick();
        check("race_at_step", (step_q.size() > 3) ? 32'(step_q[3]) : 32'hFFFF_FFFF, 32'(w));
        check("race_count", 32'(step_q.size()), 32'd5);
        rd_check("race_gen", A_GEN, 32'd1);

        // Paused display channel 1 frame handshake and busy falling edge
        wr(32'h108, 32'h7);
        repeat (2) tick();
        check("disp_frame_req", 32'(disp_frame), 32'h3);
        check("disp_enable", 32'(disp_en), 32'h2);
        disp_busy = 2'b10;
        repeat (3) tick();
        check("disp_frame_drop", 32'(disp_frame), 32'h1);
        rd_check("disp1_busy_rd", 32'h108, 32'hB);
        rd_check("disp0_rd", 32'h100, 32'h4);
        disp_busy = 2'b00;
        repeat (3) tick();
        rd_check("disp_irqstat", A_IRQS, IRQ_ON ? 32'd2 : 32'd0);
        check("disp_irq_masked", {31'd0, irq}, 32'd0);
        wr(A_IRQE, 32'd2);
        repeat (2) tick();
        check("disp_irq", {31'd0, irq}, IRQ_ON ? 32'd1 : 32'd0);
        wr(A_IRQS, 32'd2);
        wr(A_IRQE, 32'd0);
        repeat (2) tick();
        check("disp_irq_clr", {31'd0, irq}, 32'd0);

        // Reset between a single-step write and its strobe cancels it
        step_q.delete();
        wb_xfer(1'b1, A_CTRL, 32'd2, rd, c);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        check("rst_cancel_step", 32'(step_q.size()), 32'd0);
        rd_check("rst_gen", A_GEN, 32'd0);
        rd_check("rst_disp1", 32'h108, 32'h4);
        check("rst_bright2", 32'(disp_bright), 32'hFF);
        check("rst_frame2", 32'(disp_frame), 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
